demux_1_8_serializer: RTL

Upstream feeder for the 1:8 demultiplexer. Accepts a parallel data word and a 3-bit channel number over a valid/ready handshake. Drives the demux select lines (a, b, c) and serial data line D so that the word's bits appear, MSB first, on the chosen output Y1..Y8. Enforces a fixed idle gap between frames so that downstream consumers can delimit words.

---
 rtl/demux_1_8_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/demux_1_8_serializer.sv
// Serializer feeding a 1:8 demux. It captures a word and a channel, then shifts the
// word out MSB first on D, followed by a fixed idle gap.
module demux_1_8_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_ch,
    input  logic [WIDTH-1:0] in_data,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             D,
    output logic             busy,
    output logic             frame_done
);
    localparam int MAXV = (WIDTH > GAP) ? ((WIDTH > 2) ? WIDTH : 2)
                                        : ((GAP > 2) ? GAP : 2);
    localparam int CW = $clog2(MAXV);
    localparam logic [CW-1:0] CNT_W = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_G = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       sel, sel_n;
    logic             d_q, d_n, busy_q, busy_n, done_q, done_n;

    assign in_ready   = (state == IDLE) && !rst;
    assign {a, b, c}  = sel;
    assign D          = d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            sel    <= '0;
            d_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            cnt    <= cnt_n;
            sel    <= sel_n;
            d_q    <= d_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    // D is registered, so it is loaded with the bit the register will present next cycle.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        sel_n   = sel;
        d_n     = 1'b0;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (in_valid && in_ready) begin
                    state_n = SHIFT;
                    sreg_n  = in_data;
                    cnt_n   = CNT_W;
                    sel_n   = in_ch;
                    d_n     = in_data[WIDTH-1];
                    busy_n  = 1'b1;
                end
            end
            SHIFT: begin
                sreg_n = sreg << 1;
                if (cnt == '0) begin
                    done_n = 1'b1;
                    if (GAP == 0) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = GAPS;
                        cnt_n   = CNT_G;
                        busy_n  = 1'b1;
                    end
                end else begin
                    cnt_n  = cnt - CW'(1);
                    d_n    = sreg_n[WIDTH-1];
                    busy_n = 1'b1;
                end
            end
            GAPS: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n  = cnt - CW'(1);
                    busy_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule
